// File: rtl/band_power_normalizer.sv
// Band-power normalizer: captures five EEG band powers, clamps negatives to zero,
// and divides each band by the total with one shared restoring divider to give
// unsigned Q1.(FRAC_BITS) relative powers, handed downstream over valid/ready.
module band_power_normalizer #(
  parameter int unsigned FRAC_BITS = 15,
  parameter int unsigned IN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i_power_valid,
  input  logic [IN_WIDTH-1:0]   i_delta_power,
  input  logic [IN_WIDTH-1:0]   i_theta_power,
  input  logic [IN_WIDTH-1:0]   i_alpha_power,
  input  logic [IN_WIDTH-1:0]   i_beta_power,
  input  logic [IN_WIDTH-1:0]   i_gamma_power,
  input  logic                  i_feature_ready,
  output logic [FRAC_BITS:0]    o_rel_delta,
  output logic [FRAC_BITS:0]    o_rel_theta,
  output logic [FRAC_BITS:0]    o_rel_alpha,
  output logic [FRAC_BITS:0]    o_rel_beta,
  output logic [FRAC_BITS:0]    o_rel_gamma,
  output logic [IN_WIDTH+2:0]   o_total_power,
  output logic                  o_zero_power,
  output logic                  o_feature_valid,
  output logic                  o_busy,
  output logic                  o_dropped
);

  localparam int unsigned QW = FRAC_BITS + 1;   // quotient width, one bit per divide cycle
  localparam int unsigned TW = IN_WIDTH + 3;    // total width, sum of five can't overflow
  localparam int unsigned RW = IN_WIDTH + 4;    // remainder width, holds 2*rem without loss
  localparam int unsigned NB = 5;
  localparam int unsigned CW = $clog2(QW);

  typedef enum logic [1:0] {StIdle, StSum, StDiv, StOut} state_e;

  state_e              state_q;
  logic                valid_prev_q;
  logic [IN_WIDTH-1:0] band_q [NB];
  logic [FRAC_BITS:0]  rel_q  [NB];
  logic [2:0]          idx_q;
  logic [CW-1:0]       cnt_q;
  logic [RW-1:0]       rem_q;
  logic [QW-1:0]       quot_q;
  logic [TW-1:0]       total_q;
  logic                zero_q;
  logic                fvalid_q;
  logic                dropped_q;

  logic                capture;
  logic [TW-1:0]       sum_total;
  logic [IN_WIDTH-1:0] cur_band;
  logic [RW-1:0]       dividend;
  logic [RW-1:0]       total_ext;
  logic                ge;
  logic [RW-1:0]       rem_next;
  logic [QW-1:0]       quot_next;

  function automatic logic [IN_WIDTH-1:0] clamp(input logic [IN_WIDTH-1:0] x);
    return x[IN_WIDTH-1] ? '0 : x;
  endfunction

  assign capture   = i_power_valid & ~valid_prev_q;
  assign sum_total = TW'(band_q[0]) + TW'(band_q[1]) + TW'(band_q[2]) + TW'(band_q[3]) +
                     TW'(band_q[4]);
  assign total_ext = {1'b0, total_q};

  // One restoring-divide step: first cycle loads the band, later cycles shift the remainder.
  always_comb begin
    cur_band = '0;
    case (idx_q)
      3'd0:    cur_band = band_q[0];
      3'd1:    cur_band = band_q[1];
      3'd2:    cur_band = band_q[2];
      3'd3:    cur_band = band_q[3];
      3'd4:    cur_band = band_q[4];
      default: cur_band = '0;
    endcase
    if (cnt_q == '0) dividend = {{(RW-IN_WIDTH){1'b0}}, cur_band};
    else             dividend = rem_q << 1;
    ge        = (dividend >= total_ext);
    rem_next  = ge ? (dividend - total_ext) : dividend;
    quot_next = {quot_q[QW-2:0], ge};
  end

  // Control FSM with all outputs registered; en low clears everything like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_prev_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      total_q      <= '0;
      zero_q       <= 1'b0;
      fvalid_q     <= 1'b0;
      dropped_q    <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        band_q[i] <= '0;
        rel_q[i]  <= '0;
      end
    end else if (!en) begin
      state_q      <= StIdle;
      valid_prev_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      total_q      <= '0;
      zero_q       <= 1'b0;
      fvalid_q     <= 1'b0;
      dropped_q    <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        band_q[i] <= '0;
        rel_q[i]  <= '0;
      end
    end else begin
      valid_prev_q <= i_power_valid;
      // Edges arriving outside IDLE (including on the OUT->IDLE edge) are discarded.
      dropped_q    <= capture && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (capture) begin
            band_q[0] <= clamp(i_delta_power);
            band_q[1] <= clamp(i_theta_power);
            band_q[2] <= clamp(i_alpha_power);
            band_q[3] <= clamp(i_beta_power);
            band_q[4] <= clamp(i_gamma_power);
            state_q   <= StSum;
          end
        end
        StSum: begin
          total_q <= sum_total;
          if (sum_total == '0) begin
            zero_q <= 1'b1;
            for (int i = 0; i < NB; i++) rel_q[i] <= '0;
            state_q <= StOut;
          end else begin
            zero_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q  <= rem_next;
          quot_q <= quot_next;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(QW - 1)) begin
            cnt_q <= '0;
            case (idx_q)
              3'd0:    rel_q[0] <= quot_next;
              3'd1:    rel_q[1] <= quot_next;
              3'd2:    rel_q[2] <= quot_next;
              3'd3:    rel_q[3] <= quot_next;
              3'd4:    rel_q[4] <= quot_next;
              default: ;
            endcase
            if (idx_q == 3'(NB - 1)) state_q <= StOut;
            else                     idx_q   <= idx_q + 3'd1;
          end
        end
        StOut: begin
          // Valid rises one cycle after entering OUT; ready is only honoured while valid.
          if (!fvalid_q) begin
            fvalid_q <= 1'b1;
          end else if (i_feature_ready) begin
            fvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_rel_delta     = rel_q[0];
  assign o_rel_theta     = rel_q[1];
  assign o_rel_alpha     = rel_q[2];
  assign o_rel_beta      = rel_q[3];
  assign o_rel_gamma     = rel_q[4];
  assign o_total_power   = total_q;
  assign o_zero_power    = zero_q;
  assign o_feature_valid = fvalid_q;
  assign o_busy          = (state_q != StIdle);
  assign o_dropped       = dropped_q;

endmodule

// File: tb/tb_band_power_normalizer.sv
// Directed bench for band_power_normalizer with hand-computed expectations.
module tb_band_power_normalizer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        i_power_valid;
  logic [31:0] i_delta_power;
  logic [31:0] i_theta_power;
  logic [31:0] i_alpha_power;
  logic [31:0] i_beta_power;
  logic [31:0] i_gamma_power;
  logic        i_feature_ready;
  logic [15:0] o_rel_delta;
  logic [15:0] o_rel_theta;
  logic [15:0] o_rel_alpha;
  logic [15:0] o_rel_beta;
  logic [15:0] o_rel_gamma;
  logic [34:0] o_total_power;
  logic        o_zero_power;
  logic        o_feature_valid;
  logic        o_busy;
  logic        o_dropped;

  int n_cmp = 0;
  int n_err = 0;

  band_power_normalizer #(
    .FRAC_BITS (15),
    .IN_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .i_power_valid   (i_power_valid),
    .i_delta_power   (i_delta_power),
    .i_theta_power   (i_theta_power),
    .i_alpha_power   (i_alpha_power),
    .i_beta_power    (i_beta_power),
    .i_gamma_power   (i_gamma_power),
    .i_feature_ready (i_feature_ready),
    .o_rel_delta     (o_rel_delta),
    .o_rel_theta     (o_rel_theta),
    .o_rel_alpha     (o_rel_alpha),
    .o_rel_beta      (o_rel_beta),
    .o_rel_gamma     (o_rel_gamma),
    .o_total_power   (o_total_power),
    .o_zero_power    (o_zero_power),
    .o_feature_valid (o_feature_valid),
    .o_busy          (o_busy),
    .o_dropped       (o_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse a capture, then count edges until valid rises (bounded).
  task automatic run(input logic [31:0] d, input logic [31:0] t, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] g, input int exp_lat,
                     input string tag);
    int lat;
    i_delta_power = d;
    i_theta_power = t;
    i_alpha_power = a;
    i_beta_power  = b;
    i_gamma_power = g;
    i_power_valid = 1'b1;
    step();
    i_power_valid = 1'b0;
    check({tag, "_busy"}, 64'(o_busy), 64'd1);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (o_feature_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [15:0] ed, input logic [15:0] et,
                           input logic [15:0] ea, input logic [15:0] eb,
                           input logic [15:0] eg, input logic [34:0] etot,
                           input logic ez);
    check({tag, "_delta"}, 64'(o_rel_delta), 64'(ed));
    check({tag, "_theta"}, 64'(o_rel_theta), 64'(et));
    check({tag, "_alpha"}, 64'(o_rel_alpha), 64'(ea));
    check({tag, "_beta"},  64'(o_rel_beta),  64'(eb));
    check({tag, "_gamma"}, 64'(o_rel_gamma), 64'(eg));
    check({tag, "_total"}, 64'(o_total_power), 64'(etot));
    check({tag, "_zero"},  64'(o_zero_power), 64'(ez));
  endtask

  task automatic accept(input string tag);
    i_feature_ready = 1'b1;
    step();
    check({tag, "_acc_valid"}, 64'(o_feature_valid), 64'd0);
    check({tag, "_acc_busy"},  64'(o_busy), 64'd0);
    i_feature_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    i_power_valid = 1'b0;
    i_delta_power = '0;
    i_theta_power = '0;
    i_alpha_power = '0;
    i_beta_power  = '0;
    i_gamma_power = '0;
    i_feature_ready = 1'b0;
    repeat (3) step();
    check("rst_valid",   64'(o_feature_valid), 64'd0);
    check("rst_busy",    64'(o_busy), 64'd0);
    check("rst_dropped", 64'(o_dropped), 64'd0);
    check_res("rst", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 35'd0, 1'b0);
    rst = 1'b0;
    en = 1'b1;
    step();

    // Equal bands: 100/500 -> floor(32768/5) = 6553
    run(32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 82, "eq");
    check_res("eq", 16'd6553, 16'd6553, 16'd6553, 16'd6553, 16'd6553, 35'd500, 1'b0);
    accept("eq");

    // Single band takes everything
    run(32'd1000, 32'd0, 32'd0, 32'd0, 32'd0, 82, "one");
    check_res("one", 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 35'd1000, 1'b0);
    accept("one");

    // Negative theta clamps to zero
    run(32'd0, 32'hFFFF_FFFB, 32'd300, 32'd0, 32'd0, 82, "neg");
    check_res("neg", 16'd0, 16'd0, 16'h8000, 16'd0, 16'd0, 35'd300, 1'b0);
    accept("neg");

    // Zero total short-cuts to OUT
    run(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2, "zero");
    check_res("zero", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 35'd0, 1'b1);
    accept("zero");

    // Full-scale inputs: total 5*(2^31-1) = 0x27FFFFFFB
    run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 82, "max");
    check_res("max", 16'd6553, 16'd6553, 16'd6553, 16'd6553, 16'd6553, 35'h2_7FFF_FFFB, 1'b0);
    accept("max");

    // Mixed 1,2,3,4,10 over 20: 1638, 3276, 4915, 6553, 16384
    run(32'd1, 32'd2, 32'd3, 32'd4, 32'd10, 82, "mix");
    check_res("mix", 16'd1638, 16'd3276, 16'd4915, 16'd6553, 16'd16384, 35'd20, 1'b0);
    accept("mix");

    // Backpressure with an ignored capture edge while in OUT
    run(32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 82, "bp");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) i_power_valid = 1'b1;
      step();
      check("bp_hold_valid", 64'(o_feature_valid), 64'd1);
      check("bp_hold_rel",   64'(o_rel_gamma), 64'd6553);
      check("bp_hold_total", 64'(o_total_power), 64'd500);
      if (i == 3) check("bp_drop_pulse", 64'(o_dropped), 64'd1);
      if (i == 4) check("bp_drop_end",   64'(o_dropped), 64'd0);
    end
    accept("bp");
    i_power_valid = 1'b0;
    step();
    check("bp_no_recapture", 64'(o_busy), 64'd0);

    // Asynchronous reset in the middle of the divide
    i_delta_power = 32'd100;
    i_theta_power = 32'd100;
    i_alpha_power = 32'd100;
    i_beta_power  = 32'd100;
    i_gamma_power = 32'd100;
    i_power_valid = 1'b1;
    step();
    i_power_valid = 1'b0;
    repeat (30) step();
    check("mid_busy",  64'(o_busy), 64'd1);
    check("mid_delta", 64'(o_rel_delta), 64'd6553);
    rst = 1'b1;
    #2;
    check("arst_total", 64'(o_total_power), 64'd0);
    check("arst_delta", 64'(o_rel_delta), 64'd0);
    check("arst_busy",  64'(o_busy), 64'd0);
    check("arst_valid", 64'(o_feature_valid), 64'd0);
    rst = 1'b0;
    step();

    // Valid held high across en 1->0->1 is re-detected; ready already high gives 1-cycle valid
    i_delta_power = '0;
    i_theta_power = '0;
    i_alpha_power = '0;
    i_beta_power  = '0;
    i_gamma_power = '0;
    i_feature_ready = 1'b1;
    i_power_valid = 1'b1;
    step();
    check("en_cap1_busy", 64'(o_busy), 64'd1);
    step();
    step();
    check("en_cap1_valid", 64'(o_feature_valid), 64'd1);
    check("en_cap1_zero",  64'(o_zero_power), 64'd1);
    step();
    check("en_valid_1cyc", 64'(o_feature_valid), 64'd0);
    repeat (3) step();
    check("en_level_idle", 64'(o_busy), 64'd0);
    en = 1'b0;
    step();
    check("en_off_busy", 64'(o_busy), 64'd0);
    en = 1'b1;
    step();
    check("en_cap2_busy", 64'(o_busy), 64'd1);
    step();
    step();
    check("en_cap2_valid", 64'(o_feature_valid), 64'd1);
    step();
    i_power_valid = 1'b0;
    i_feature_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/band_power_normalizer.md
Name: band_power_normalizer

Overview:
- Downstream stage of the band-power calculator. Captures the five accumulated EEG band powers (delta, theta, alpha, beta, gamma) when the upstream valid asserts.
- Computes each band's share of total power as an unsigned Q1.15 fraction using one shared sequential restoring divider.
- Presents the five relative powers plus the total to the classifier through a valid/ready handshake.

Parameters:
- FRAC_BITS, 15, fractional bits of each relative-power output. Output width is FRAC_BITS+1.
- IN_WIDTH, 32, width of each signed band-power input.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  block enable; low = synchronous clear to IDLE
- i_power_valid  input  1  upstream valid; level signal that may stay high for many cycles
- i_delta_power  input  IN_WIDTH  signed delta band power
- i_theta_power  input  IN_WIDTH  signed theta band power
- i_alpha_power  input  IN_WIDTH  signed alpha band power
- i_beta_power  input  IN_WIDTH  signed beta band power
- i_gamma_power  input  IN_WIDTH  signed gamma band power
- i_feature_ready  input  1  downstream ready
- o_rel_delta, o_rel_theta, o_rel_alpha, o_rel_beta, o_rel_gamma  output  FRAC_BITS+1 each  unsigned Q1.15 band/total
- o_total_power  output  IN_WIDTH+3  unsigned sum of clamped inputs
- o_zero_power  output  1  total was zero for the current result
- o_feature_valid  output  1  result valid, held until accepted
- o_busy  output  1  high in any state other than IDLE
- o_dropped  output  1  one-cycle pulse when an input edge is ignored

Behaviour:
- Reset and clear: rst (asynchronous) or en=0 (synchronous) forces state IDLE. All outputs go to 0, as do the edge-detect register, the divider registers and the band index.
- Edge detect: a capture event is i_power_valid=1 while the previous-cycle registered i_power_valid=0. Because the edge register clears to 0, an input held high when en rises is detected as a new edge.
- Input clamp: negative inputs are treated as 0 at capture. The five clamped values are stored internally.
- States: IDLE, SUM, DIV, OUT.
- IDLE: on a capture event, register the clamped inputs and go to SUM.
- SUM:
  - total = sum of the five clamped values (IN_WIDTH+3 bits, no overflow possible); register it into o_total_power.
  - If total==0: all o_rel_* = 0, o_zero_power=1, go to OUT.
  - Otherwise: o_zero_power=0, band index=0 (delta), go to DIV.
- DIV: 16 cycles per band, bands in order delta, theta, alpha, beta, gamma.
  - Cycle 0: q[15] = (band >= total); rem = band - q[15]*total.
  - Cycles 1..15: rem <<= 1; if rem >= total then rem -= total and q[15-k] = 1, else q[15-k] = 0.
  - rem is IN_WIDTH+4 bits. The result equals floor(band*2^15/total), truncated, with a maximum of 0x8000.
  - At the end of each band, write q to the matching o_rel_* register. After gamma, go to OUT.
- OUT: o_feature_valid=1. All outputs stay stable until i_feature_ready=1 on a clock edge; that edge returns the block to IDLE with o_feature_valid=0. If ready is already high on entry, the valid is one cycle long.
- Latency, counted from the capture edge:
  - nonzero total: o_feature_valid rises 82 edges later (SUM 1 + DIV 80 + 1);
  - zero total: o_feature_valid rises 2 edges later.
- o_rel_* update band by band during DIV. They are meaningful only while o_feature_valid=1.
- Capture event while not in IDLE: ignored. o_dropped pulses for 1 cycle, and the stored inputs are unchanged.
- An OUT→IDLE transition and a capture event on the same edge: the edge is dropped (pulse). The next rising edge is accepted.
- Invariant: the sum of the five o_rel_* is ≤ 32768 and ≥ 32768-5.

Test Plan:
- All five inputs = 100 -> total 500; each o_rel = 6553 (0x1999); o_feature_valid rises 82 cycles after capture; o_zero_power=0.
- delta=1000, others 0 -> o_rel_delta=0x8000, the other four = 0, o_total_power=1000.
- theta=-5, alpha=300, others 0 -> theta clamped to 0; o_rel_alpha=0x8000, o_total_power=300.
- All inputs 0 -> o_zero_power=1, all o_rel = 0, o_feature_valid after 2 cycles.
- All inputs 0x7FFFFFFF -> o_total_power = 5*(2^31-1), each o_rel = 6553, no overflow.
- Backpressure and drop:
  - hold i_feature_ready=0 for 10 cycles in OUT -> outputs stable; a new i_power_valid rising edge meanwhile -> o_dropped 1-cycle pulse; ready=1 -> IDLE.
  - assert rst mid-DIV -> all outputs 0 immediately.
  - hold i_power_valid high across en toggling 1→0→1 -> new capture.
